// File: rtl/switch_debounce_fsm.sv
// switch_debounce_fsm: debounces a raw switch on rising edges of a slow toggle sampled as data
module switch_debounce_fsm #(
    parameter int STABLE_SAMPLES = 3,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_slow_clk,
    input  logic                 i_sw,
    output logic                 o_sw_db,
    output logic                 o_press,
    output logic                 o_release,
    output logic [CNT_WIDTH-1:0] o_press_cnt
);
    typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;
    localparam logic [7:0] SS = 8'(STABLE_SAMPLES);
    localparam logic ONE_SAMPLE = (SS == 8'd1);
    state_t     state, state_n;
    logic [7:0] scnt, scnt_n, scnt_inc;
    logic [1:0] sw_sync, sc_sync;
    logic       sc_d, sw_s, tick, press_n, release_n;
    assign sw_s     = sw_sync[1];
    assign tick     = sc_sync[1] & ~sc_d;
    assign scnt_inc = scnt + 8'd1;
    // synchronizers, edge history, FSM registers and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_sync     <= '0;
            sc_sync     <= '0;
            sc_d        <= 1'b0;
            state       <= LOW;
            scnt        <= '0;
            o_sw_db     <= 1'b0;
            o_press     <= 1'b0;
            o_release   <= 1'b0;
            o_press_cnt <= '0;
        end else begin
            sw_sync     <= {sw_sync[0], i_sw};
            sc_sync     <= {sc_sync[0], i_slow_clk};
            sc_d        <= sc_sync[1];
            state       <= state_n;
            scnt        <= scnt_n;
            o_sw_db     <= (state_n == HIGH) || (state_n == FALL);
            o_press     <= press_n;
            o_release   <= release_n;
            o_press_cnt <= o_press_cnt + CNT_WIDTH'(press_n);
        end
    end
    // next state and strobes; only a tick cycle may move the FSM
    always_comb begin
        state_n   = state;
        scnt_n    = scnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        if (tick) begin
            case (state)
                LOW: if (sw_s) begin
                    state_n = ONE_SAMPLE ? HIGH : RISE;
                    scnt_n  = ONE_SAMPLE ? 8'd0 : 8'd1;
                    press_n = ONE_SAMPLE;
                end
                RISE: begin
                    state_n = !sw_s ? LOW : (scnt_inc == SS) ? HIGH : RISE;
                    scnt_n  = (!sw_s || scnt_inc == SS) ? 8'd0 : scnt_inc;
                    press_n = sw_s && scnt_inc == SS;
                end
                HIGH: if (!sw_s) begin
                    state_n   = ONE_SAMPLE ? LOW : FALL;
                    scnt_n    = ONE_SAMPLE ? 8'd0 : 8'd1;
                    release_n = ONE_SAMPLE;
                end
                FALL: begin
                    state_n   = sw_s ? HIGH : (scnt_inc == SS) ? LOW : FALL;
                    scnt_n    = (sw_s || scnt_inc == SS) ? 8'd0 : scnt_inc;
                    release_n = !sw_s && scnt_inc == SS;
                end
                default: state_n = LOW;
            endcase
        end
    end
endmodule

// File: tb/tb_switch_debounce_fsm.sv
// tb_switch_debounce_fsm: directed scoreboard bench for the slow-tick switch debouncer
module tb_switch_debounce_fsm;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_slow_clk = 1'b0;
    logic       i_sw = 1'b0;
    logic       db_a, pr_a, rl_a, db_b, pr_b, rl_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    int         vectors = 0;
    int         errors = 0;

    typedef struct {
        string      tag;
        logic       db;
        logic       pr;
        logic       rl;
        logic [7:0] ca;
        logic [1:0] cb;
    } exp_t;
    exp_t sb[$];

    switch_debounce_fsm dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_slow_clk(i_slow_clk), .i_sw(i_sw),
        .o_sw_db(db_a), .o_press(pr_a), .o_release(rl_a), .o_press_cnt(cnt_a)
    );

    switch_debounce_fsm #(.STABLE_SAMPLES(3), .CNT_WIDTH(2)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_slow_clk(i_slow_clk), .i_sw(i_sw),
        .o_sw_db(db_b), .o_press(pr_b), .o_release(rl_b), .o_press_cnt(cnt_b)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic db, input logic pr,
                              input logic rl, input logic [7:0] ca, input logic [1:0] cb);
        sb.push_back('{tag, db, pr, rl, ca, cb});
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".db_a"}, {7'd0, db_a}, {7'd0, e.db});
            chk({e.tag, ".pr_a"}, {7'd0, pr_a}, {7'd0, e.pr});
            chk({e.tag, ".rl_a"}, {7'd0, rl_a}, {7'd0, e.rl});
            chk({e.tag, ".cnt_a"}, cnt_a, e.ca);
            chk({e.tag, ".db_b"}, {7'd0, db_b}, {7'd0, e.db});
            chk({e.tag, ".pr_b"}, {7'd0, pr_b}, {7'd0, e.pr});
            chk({e.tag, ".rl_b"}, {7'd0, rl_b}, {7'd0, e.rl});
            chk({e.tag, ".cnt_b"}, {6'd0, cnt_b}, {6'd0, e.cb});
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (4) @(negedge i_clk);
        i_rst = 1'b0;
        expect_out(tag, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        @(posedge i_clk);
        #1 check_out();
    endtask

    task automatic slow_tick(input string tag, input logic sw, input logic db,
                             input logic pr, input logic rl, input logic [7:0] ca,
                             input logic [1:0] cb);
        logic prev_db;
        @(negedge i_clk);
        i_sw = sw;
        repeat (3) @(negedge i_clk);
        prev_db = db_a;
        i_slow_clk = 1'b1;
        expect_out(tag, db, pr, rl, ca, cb);
        repeat (2) @(posedge i_clk);
        #1 chk({tag, ".early_db"}, {7'd0, db_a}, {7'd0, prev_db});
        @(posedge i_clk);
        #1 check_out();
        @(posedge i_clk);
        #1 chk({tag, ".strobe_gone"}, {6'd0, pr_a, rl_a}, 8'd0);
        repeat (6) @(negedge i_clk);
        i_slow_clk = 1'b0;
        repeat (6) @(negedge i_clk);
    endtask

    initial begin
        do_reset("reset");
        i_sw = 1'b1;
        repeat (25) @(negedge i_clk);
        expect_out("no_tick_low", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        check_out();

        slow_tick("press_t1", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        slow_tick("press_t2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        slow_tick("press_t3", 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 2'd1);

        slow_tick("rel_t1", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'd1);
        slow_tick("rel_t2", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'd1);
        slow_tick("rel_t3", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 2'd1);

        slow_tick("bnc_t1", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
        slow_tick("bnc_t2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
        slow_tick("bnc_t3", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
        slow_tick("bnc_t4", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
        slow_tick("bnc_t5", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
        slow_tick("bnc_t6", 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 2'd2);

        slow_tick("fbnc_t1", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 2'd2);
        slow_tick("fbnc_t2", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd2);
        slow_tick("fbnc_t3", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 2'd2);
        slow_tick("fbnc_t4", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 2'd2);
        slow_tick("fbnc_t5", 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 2'd2);

        for (int n = 3; n <= 4; n++) begin
            slow_tick("wrap_p1", 1'b1, 1'b0, 1'b0, 1'b0, 8'(n - 1), 2'(n - 1));
            slow_tick("wrap_p2", 1'b1, 1'b0, 1'b0, 1'b0, 8'(n - 1), 2'(n - 1));
            slow_tick("wrap_p3", 1'b1, 1'b1, 1'b1, 1'b0, 8'(n), 2'(n));
            slow_tick("wrap_r1", 1'b0, 1'b1, 1'b0, 1'b0, 8'(n), 2'(n));
            slow_tick("wrap_r2", 1'b0, 1'b1, 1'b0, 1'b0, 8'(n), 2'(n));
            slow_tick("wrap_r3", 1'b0, 1'b0, 1'b0, 1'b1, 8'(n), 2'(n));
        end

        slow_tick("rst_rise_t1", 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 2'd0);
        slow_tick("rst_rise_t2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 2'd0);
        do_reset("mid_rise_reset");
        slow_tick("fresh_t1", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        slow_tick("fresh_t2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        slow_tick("fresh_t3", 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 2'd1);

        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/switch_debounce_fsm.md
# switch_debounce_fsm

Debounce stage fed by the slow toggle divider. It treats the divider's ~5 Hz square wave (100 MHz / 20,000,000) as data, not as a clock, and turns each of its rising edges into a one-cycle sample tick in the `i_clk` domain. On each tick it samples a synchronized raw switch and drives a clean debounced level, one-cycle press and release strobes, and a wrapping press counter for downstream LED/display logic.

## Interface
Parameters:
- `STABLE_SAMPLES`, default 3: consecutive agreeing ticks needed to change the debounced level. Legal range is 1..255.
- `CNT_WIDTH`, default 8: width of the press counter.

Ports:
- `i_clk`, input, 1: system clock (100 MHz). This is the only clock.
- `i_rst`, input, 1: reset, synchronous and active-high.
- `i_slow_clk`, input, 1: slow toggle from the divider. It is sampled as data and is asynchronous to this block's logic.
- `i_sw`, input, 1: raw mechanical switch, asynchronous and bouncing.
- `o_sw_db`, output, 1: debounced switch level.
- `o_press`, output, 1: one-`i_clk` strobe on each debounced 0->1 transition.
- `o_release`, output, 1: one-`i_clk` strobe on each debounced 1->0 transition.
- `o_press_cnt`, output, `CNT_WIDTH`: count of debounced presses, wrapping.

## Operation
Synchronizers:
- Two-flop synchronizer on `i_sw`, producing `sw_s`.
- Two-flop synchronizer on `i_slow_clk`, producing `sc_s`, plus one history flop `sc_d`.
- `tick = sc_s & ~sc_d`. This gives exactly one `i_clk` cycle per rising edge of `i_slow_clk`.
- Falling edges of `i_slow_clk` and a high level held on it produce no tick.

FSM (4 states) with sample counter `scnt` (8 bits):
- `LOW`, where `o_sw_db=0`:
  - On tick with `sw_s=1`: if `STABLE_SAMPLES==1`, go to `HIGH` and fire a press. Otherwise go to `RISE` with `scnt=1`.
- `RISE`, where `o_sw_db=0`:
  - On tick with `sw_s=1`: `scnt++`. When the new value equals `STABLE_SAMPLES`, go to `HIGH` and fire a press.
  - On tick with `sw_s=0`: go to `LOW` with `scnt=0` (bounce rejected).
- `HIGH`, where `o_sw_db=1`: mirror of `LOW`, with `sw_s=0` leading to `FALL` or directly to `LOW`.
- `FALL`, where `o_sw_db=1`: mirror of `RISE`. Completing the count goes to `LOW` and fires a release. A tick with `sw_s=1` returns to `HIGH`.
- Without a tick, the state, `scnt` and `o_sw_db` hold.

Press handling:
- A press sets `o_press=1` for one cycle and increments `o_press_cnt` modulo 2^`CNT_WIDTH` (all-ones wraps to 0).
- A release sets `o_release=1` for one cycle and leaves the counter unchanged.
- `o_press` and `o_release` are never high in the same cycle.

## Timing
- Reset values: all synchronizer and history flops 0, state `LOW`, `scnt=0`, `o_sw_db=0`, `o_press=0`, `o_release=0`, `o_press_cnt=0`.
- Reset is applied at the `i_clk` edge where `i_rst=1` and overrides any tick in that cycle.
- Reset mid-`RISE` or mid-`FALL` discards the partial count. The first post-reset sample starts a fresh count.
- After reset with `i_slow_clk` already high, one tick fires 3 cycles after `i_rst` falls. This is legal and expected.
- Tick latency: the tick is high during the 3rd `i_clk` cycle after `i_slow_clk` rises (2 synchronizer cycles plus the edge compare).
- Output latency: `o_sw_db`, `o_press`, `o_release` and `o_press_cnt` all update at the `i_clk` edge that consumes the completing tick. All outputs are registered.
- Debounce time is `STABLE_SAMPLES` slow periods. With the defaults this is 3 × 200 ms = 600 ms worst-case reaction after the last bounce.
- Simultaneous events: `sw_s` is sampled only in the tick cycle. Changes of `sw_s` between ticks are ignored.

## Test plan
Benches drive `i_slow_clk` directly, with one rising edge every 20 `i_clk` cycles.

1. Reset with `i_sw=0` and `i_slow_clk=0` for 4 cycles, then release reset -> all outputs 0. No tick while `i_slow_clk` stays 0.
2. `STABLE_SAMPLES=3`, `i_sw=1` held clean:
   - `o_sw_db` stays 0 through ticks 1-2.
   - On tick 3: `o_sw_db=1`, `o_press` high for exactly 1 cycle, `o_press_cnt=1`.
3. Bounce on press: `i_sw=1` for 2 ticks, then 0 at tick 3, then 1 for 3 more ticks -> no output change until the 6th tick. Then a single press and `o_press_cnt=1`.
4. Release from `HIGH`: `i_sw=0` for 3 ticks -> `o_sw_db=0` on the 3rd tick, one `o_release` pulse, `o_press_cnt` unchanged.
5. `CNT_WIDTH=2`, 4 full clean press/release cycles -> `o_press_cnt` goes 1, 2, 3, 0.
6. Reset asserted in `RISE` after 2 agreeing ticks, with `i_sw` still 1 -> `LOW` and outputs 0. `o_sw_db` rises only after 3 fresh post-reset ticks.
